// File: rtl/imem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency instruction memory between
// NUM_CORES fetch ports; one transaction is in flight at a time.
module imem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [IDX_W-1:0]     owner, owner_nx;
  logic [IDX_W-1:0]     last_owner, last_nx;
  logic [NUM_CORES-1:0] gnt_nx, rvalid_nx;
  logic [DATA_W-1:0]    rdata_nx;
  logic                 mem_en_nx;
  logic [ADDR_W-1:0]    mem_addr_nx;

  logic [ADDR_W-1:0]    core_addr [NUM_CORES];
  logic [IDX_W-1:0]     winner;
  logic                 launch;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_addr
    assign core_addr[i] = addr[i*ADDR_W +: ADDR_W];
  end

  // Smallest offset from last_owner+1 wins, so the previous owner ranks last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] r,
                                               input logic [IDX_W-1:0]     last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    pick = last;
    for (int k = NUM_CORES; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % NUM_CORES);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign winner = rr_pick(req, last_owner);
  assign launch = ((state == IDLE) || (state == RESP)) && (|req);
  assign busy   = (state == WAIT) || (state == CAPTURE);

  always_comb begin
    // NOTE: every value gets a default first so no latch can be inferred.
    state_nx    = state;
    cnt_nx      = cnt;
    owner_nx    = owner;
    last_nx     = last_owner;
    gnt_nx      = '0;
    rvalid_nx   = '0;
    rdata_nx    = rdata;
    mem_en_nx   = 1'b0;
    mem_addr_nx = mem_addr;

    unique case (state)
      IDLE: begin
        if (!launch) state_nx = IDLE;
      end
      WAIT: begin
        if (cnt == '0) state_nx = CAPTURE;
        else           cnt_nx   = cnt - 1'b1;
      end
      CAPTURE: begin
        rdata_nx = mem_rdata;
        state_nx = RESP;
      end
      RESP: begin
        rvalid_nx = NUM_CORES'(1) << owner;
        if (!launch) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // A new transaction can start from IDLE or overlap the RESP cycle.
    if (launch) begin
      gnt_nx      = NUM_CORES'(1) << winner;
      mem_en_nx   = 1'b1;
      mem_addr_nx = core_addr[winner];
      owner_nx    = winner;
      last_nx     = winner;
      cnt_nx      = CNT_W'(MEM_LAT - 1);
      state_nx    = WAIT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_CORES - 1);
      gnt        <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_nx;
      cnt        <= cnt_nx;
      owner      <= owner_nx;
      last_owner <= last_nx;
      gnt        <= gnt_nx;
      rvalid     <= rvalid_nx;
      rdata      <= rdata_nx;
      mem_en     <= mem_en_nx;
      mem_addr   <= mem_addr_nx;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, hand sequences for reset and
// contention, and a random run against a transaction-timeline reference model.
module tb_imem_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v       [2];
  logic [N*AW-1:0] addr_v      [2];
  logic [DW-1:0]   mem_rdata_v [2];

  logic [N-1:0]  gnt0, gnt1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic          men0, men1, busy0, busy1;
  logic [AW-1:0] ma0, ma1;

  logic [N-1:0]  gnt_a [2];
  logic [N-1:0]  rv_a  [2];
  logic [DW-1:0] rd_a  [2];
  logic          men_a [2];
  logic          busy_a[2];
  logic [AW-1:0] ma_a  [2];

  imem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req_v[0]), .addr(addr_v[0]), .gnt(gnt0),
    .rvalid(rv0), .rdata(rd0), .mem_en(men0), .mem_addr(ma0),
    .mem_rdata(mem_rdata_v[0]), .busy(busy0));

  imem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_v[1]), .addr(addr_v[1]), .gnt(gnt1),
    .rvalid(rv1), .rdata(rd1), .mem_en(men1), .mem_addr(ma1),
    .mem_rdata(mem_rdata_v[1]), .busy(busy1));

  always_comb begin
    gnt_a[0] = gnt0;  gnt_a[1] = gnt1;
    rv_a[0]  = rv0;   rv_a[1]  = rv1;
    rd_a[0]  = rd0;   rd_a[1]  = rd1;
    men_a[0] = men0;  men_a[1] = men1;
    busy_a[0] = busy0; busy_a[1] = busy1;
    ma_a[0]  = ma0;   ma_a[1]  = ma1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory: data for a read is on mem_rdata exactly MEM_LAT cycles after the
  // mem_en cycle; any other cycle carries noise.
  logic [AW-1:0] pa [2][8];
  logic [7:0]    pv [2];
  logic [DW-1:0] noise [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 7; k >= 1; k--) pa[i][k] <= pa[i][k-1];
      pa[i][0] <= ma_a[i];
      pv[i]    <= {pv[i][6:0], men_a[i]};
      noise[i] <= $urandom;
    end
  end

  always_comb begin
    mem_rdata_v[0] = pv[0][LAT0-1] ? mem_word(pa[0][LAT0-1]) : noise[0];
    mem_rdata_v[1] = pv[1][LAT1-1] ? mem_word(pa[1][LAT1-1]) : noise[1];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] core_addr(input int i);
    return 32'h100 + 32'h10 * i;
  endfunction

  // Directed vectors for instance 0 (MEM_LAT=2): row r is applied and observed in cycle r.
  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         men;
    logic [31:0]  maddr;
    logic [N-1:0] rv;
    logic [31:0]  rdat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [N-1:0] r, input logic [N-1:0] g, input logic m,
                     input logic [31:0] ma, input logic [N-1:0] v, input logic [31:0] d);
    vec_t e;
    e.req = r; e.gnt = g; e.men = m; e.maddr = ma; e.rv = v; e.rdat = d;
    tbl.push_back(e);
  endtask

  // Reference model: each accepted request occupies a fixed timeline measured
  // from its arbitration cycle T (gnt at T+1, data at T+L+2, rvalid at T+L+3,
  // next arbitration allowed at T+L+2).
  typedef struct {
    int          cyc;
    int          core;
    logic [31:0] data;
  } ev_t;

  ev_t         rv_q [2][$];
  ev_t         rd_q [2][$];
  int          m_last [2];
  int          m_next [2];
  int          m_gcyc [2];
  int          m_gcore[2];
  logic [31:0] m_gaddr[2];
  logic [31:0] m_maddr[2];
  logic [31:0] m_rdata[2];

  function automatic int rr_ref(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rv_q[i].delete();
      rd_q[i].delete();
      m_last[i]  = N - 1;
      m_next[i]  = 0;
      m_gcyc[i]  = -100;
      m_gcore[i] = 0;
      m_gaddr[i] = '0;
      m_maddr[i] = '0;
      m_rdata[i] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] eg, erv;
    logic         emen, ebusy;
    int           gcyc[5], gidx[5], ng, lat, w;
    ev_t          ev;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v[i]  = '0;
      addr_v[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d gnt", i),    gnt_a[i],  0);
      check($sformatf("reset%0d rvalid", i), rv_a[i],   0);
      check($sformatf("reset%0d mem_en", i), men_a[i],  0);
      check($sformatf("reset%0d busy", i),   busy_a[i], 0);
      check($sformatf("reset%0d rdata", i),  rd_a[i],   0);
      check($sformatf("reset%0d mem_addr", i), ma_a[i], 0);
    end

    for (int j = 0; j < N; j++) addr_v[0][j*AW +: AW] = core_addr(j);

    // single request; 1010 after owner 1; late request during WAIT
    add(4'b0001, 4'b0000, 0, 32'h000, 4'b0000, 0);
    add(4'b0000, 4'b0001, 1, 32'h100, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h100, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h100, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h100, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h100, 4'b0001, 32'hDEADBEEF);
    add(4'b0010, 4'b0000, 0, 32'h100, 4'b0000, 0);
    add(4'b1010, 4'b0010, 1, 32'h110, 4'b0000, 0);
    add(4'b1010, 4'b0000, 0, 32'h110, 4'b0000, 0);
    add(4'b1010, 4'b0000, 0, 32'h110, 4'b0000, 0);
    add(4'b1010, 4'b0000, 0, 32'h110, 4'b0000, 0);
    add(4'b0010, 4'b1000, 1, 32'h130, 4'b0010, mem_word(32'h110));
    add(4'b0010, 4'b0000, 0, 32'h130, 4'b0000, 0);
    add(4'b0010, 4'b0000, 0, 32'h130, 4'b0000, 0);
    add(4'b0010, 4'b0000, 0, 32'h130, 4'b0000, 0);
    add(4'b0000, 4'b0010, 1, 32'h110, 4'b1000, mem_word(32'h130));
    add(4'b0000, 4'b0000, 0, 32'h110, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h110, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h110, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h110, 4'b0010, mem_word(32'h110));
    add(4'b0001, 4'b0000, 0, 32'h110, 4'b0000, 0);
    add(4'b0100, 4'b0001, 1, 32'h100, 4'b0000, 0);
    add(4'b0100, 4'b0000, 0, 32'h100, 4'b0000, 0);
    add(4'b0100, 4'b0000, 0, 32'h100, 4'b0000, 0);
    add(4'b0100, 4'b0000, 0, 32'h100, 4'b0000, 0);
    add(4'b0000, 4'b0100, 1, 32'h120, 4'b0001, 32'hDEADBEEF);
    add(4'b0000, 4'b0000, 0, 32'h120, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h120, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h120, 4'b0000, 0);
    add(4'b0000, 4'b0000, 0, 32'h120, 4'b0100, mem_word(32'h120));

    rst = 1'b0;
    for (int r = 0; r < tbl.size(); r++) begin
      if (r > 0) tick();
      check($sformatf("tbl[%0d] gnt", r),      gnt0, tbl[r].gnt);
      check($sformatf("tbl[%0d] mem_en", r),   men0, tbl[r].men);
      check($sformatf("tbl[%0d] mem_addr", r), ma0,  tbl[r].maddr);
      check($sformatf("tbl[%0d] rvalid", r),   rv0,  tbl[r].rv);
      if (tbl[r].rv != 0) check($sformatf("tbl[%0d] rdata", r), rd0, tbl[r].rdat);
      req_v[0] = tbl[r].req;
    end

    // Reset during the mem_en cycle of a transaction.
    tick();
    req_v[0] = 4'b0001;
    tick();
    check("rstwait pre gnt", gnt0, 4'b0001);
    check("rstwait pre mem_en", men0, 1);
    req_v[0] = '0;
    #3;
    rst = 1'b1;
    #1;
    check("rstwait gnt", gnt0, 0);
    check("rstwait rvalid", rv0, 0);
    check("rstwait mem_en", men0, 0);
    check("rstwait busy", busy0, 0);
    check("rstwait rdata", rd0, 0);
    check("rstwait mem_addr", ma0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_v[0] = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("post_rst k%0d gnt", k),    gnt0, (k == 1) ? 4'b0100 : 4'b0000);
      check($sformatf("post_rst k%0d rvalid", k), rv0,  (k == 5) ? 4'b0100 : 4'b0000);
      if (k == 1) begin
        check("post_rst mem_en", men0, 1);
        check("post_rst mem_addr", ma0, 32'h120);
        req_v[0] = '0;
      end
      if (k <= 3) check($sformatf("post_rst k%0d rdata held", k), rd0, 0);
      if (k == 5) check("post_rst rdata", rd0, mem_word(32'h120));
    end

    // All four cores requesting continuously from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_v[0] = 4'b1111;
    ng = 0;
    for (int k = 1; k <= 30 && ng < 5; k++) begin
      tick();
      if (gnt0 != 0) begin
        check($sformatf("rr k%0d gnt onehot", k), $onehot(gnt0), 1);
        for (int b = 0; b < N; b++) if (gnt0[b]) gidx[ng] = b;
        gcyc[ng] = k;
        ng++;
      end
    end
    req_v[0] = '0;
    check("rr grant count", ng, 5);
    if (ng > 0) check("rr first gnt cycle", gcyc[0], 1);
    for (int j = 0; j < ng; j++) begin
      check($sformatf("rr grant %0d core", j), gidx[j], j % N);
      if (j > 0) check($sformatf("rr grant %0d spacing", j), gcyc[j] - gcyc[j-1], 4);
    end

    // MEM_LAT=1 single request on instance 1.
    for (int j = 0; j < N; j++) addr_v[1][j*AW +: AW] = core_addr(j);
    req_v[1] = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("lat1 k%0d gnt", k),    gnt1, (k == 1) ? 4'b0001 : 4'b0000);
      check($sformatf("lat1 k%0d rvalid", k), rv1,  (k == 4) ? 4'b0001 : 4'b0000);
      if (k == 1) req_v[1] = '0;
      if (k == 4) check("lat1 rdata", rd1, 32'hDEADBEEF);
    end

    // Random requests on both instances against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 1000; n++) begin
      if (n > 0) tick();
      for (int i = 0; i < 2; i++) begin
        lat  = (i == 0) ? LAT0 : LAT1;
        emen = (n == m_gcyc[i]);
        eg   = emen ? (N'(1) << m_gcore[i]) : '0;
        if (emen) m_maddr[i] = m_gaddr[i];
        erv = '0;
        if (rv_q[i].size() > 0 && rv_q[i][0].cyc == n) begin
          erv = N'(1) << rv_q[i][0].core;
          void'(rv_q[i].pop_front());
        end
        if (rd_q[i].size() > 0 && rd_q[i][0].cyc == n) begin
          m_rdata[i] = rd_q[i][0].data;
          void'(rd_q[i].pop_front());
        end
        ebusy = (n >= m_gcyc[i]) && (n <= m_gcyc[i] + lat);

        check($sformatf("rnd%0d c%0d gnt", i, n),      gnt_a[i],  eg);
        check($sformatf("rnd%0d c%0d rvalid", i, n),   rv_a[i],   erv);
        check($sformatf("rnd%0d c%0d mem_en", i, n),   men_a[i],  emen);
        check($sformatf("rnd%0d c%0d mem_addr", i, n), ma_a[i],   m_maddr[i]);
        check($sformatf("rnd%0d c%0d rdata", i, n),    rd_a[i],   m_rdata[i]);
        check($sformatf("rnd%0d c%0d busy", i, n),     busy_a[i], ebusy);
        check($sformatf("rnd%0d c%0d gnt onehot0", i, n), $onehot0(gnt_a[i]), 1);
        check($sformatf("rnd%0d c%0d rvalid onehot0", i, n), $onehot0(rv_a[i]), 1);

        for (int j = 0; j < N; j++) begin
          if (req_v[i][j]) begin
            if (eg[j]) begin
              if ($urandom_range(1, 0) == 1) addr_v[i][j*AW +: AW] = $urandom & 32'hFFFF_FFFC;
              else req_v[i][j] = 1'b0;
            end else if ($urandom_range(15, 0) == 0) begin
              req_v[i][j] = 1'b0;
            end
          end else if ($urandom_range(2, 0) == 0) begin
            req_v[i][j] = 1'b1;
            addr_v[i][j*AW +: AW] = $urandom & 32'hFFFF_FFFC;
          end
        end

        if (n >= m_next[i] && req_v[i] != 0) begin
          w          = rr_ref(req_v[i], m_last[i]);
          m_last[i]  = w;
          m_gcyc[i]  = n + 1;
          m_gcore[i] = w;
          m_gaddr[i] = addr_v[i][w*AW +: AW];
          m_next[i]  = n + lat + 2;
          ev.cyc = n + lat + 3; ev.core = w; ev.data = mem_word(m_gaddr[i]);
          rv_q[i].push_back(ev);
          ev.cyc = n + lat + 2;
          rd_q[i].push_back(ev);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
